// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, stage-enable
// and flush bit positions, and the default performance-counter width.
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    // Encoding 2'd3 is intentionally unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam int SE_PC     = 0;
    localparam int SE_IF_ID  = 1;
    localparam int SE_ID_EX  = 2;
    localparam int SE_EX_MEM = 3;
    localparam int SE_MEM_WB = 4;

    localparam int FL_IF_ID  = 0;
    localparam int FL_ID_EX  = 1;
    localparam int FL_EX_MEM = 2;

    localparam logic [4:0] STAGE_NONE = 5'b00000;
    localparam logic [4:0] STAGE_ALL  = 5'b11111;
    localparam logic [2:0] FLUSH_NONE = 3'b000;
    localparam logic [2:0] FLUSH_ALL  = 3'b111;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: the EX-stage load writes a register that the
// ID-stage instruction reads. Register 0 never creates a hazard.
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    output logic       hz_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_match = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign hz_o      = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: Mealy FSM producing stage load enables and bubble
// flushes, plus saturating stall and taken-branch flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_done,
    output logic [4:0]       stage_en,
    output logic [2:0]       flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             hz;
    logic             stall_inc;
    logic             flush_inc;

    logic [4:0]       run_se;
    logic [2:0]       run_fl;
    logic             run_stall;
    logic             run_flush;

    hazard_detect u_hazard_detect (
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .ex_rd_i      (ex_rd),
        .ex_is_load_i (ex_is_load),
        .hz_o         (hz)
    );

    // Rules shared by RUN (when memory is not blocking) and the MEM_WAIT exit
    // cycle; a taken branch squashes the hazard because the ID instruction dies.
    always_comb begin
        run_se    = STAGE_ALL;
        run_fl    = FLUSH_NONE;
        run_stall = 1'b0;
        run_flush = 1'b0;
        if (mem_branch_taken) begin
            run_fl    = FLUSH_ALL;
            run_flush = 1'b1;
        end else if (hz) begin
            run_se[SE_PC]    = 1'b0;
            run_se[SE_IF_ID] = 1'b0;
            run_fl[FL_ID_EX] = 1'b1;
            run_stall        = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        stage_en  = STAGE_NONE;
        flush     = FLUSH_NONE;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    flush   = FLUSH_ALL;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (mem_req && !mem_done) begin
                        stall_inc = 1'b1;
                        state_d   = ST_MEM_WAIT;
                    end else begin
                        stage_en  = run_se;
                        flush     = run_fl;
                        stall_inc = run_stall;
                        flush_inc = run_flush;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_done) begin
                        stall_inc = 1'b1;
                    end else begin
                        stage_en  = run_se;
                        flush     = run_fl;
                        stall_inc = run_stall;
                        flush_inc = run_flush;
                        state_d   = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the performance counters.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_in  in  1  reset; asynchronous, active-high.
REQ-004 Port: rdy_in  in  1  global ready; when low, the controller freezes.
REQ-005 Port: id_rs1  in  5  ID-stage source register 1 index.
REQ-006 Port: id_rs2  in  5  ID-stage source register 2 index.
REQ-007 Port: id_use_rs1  in  1  ID instruction reads rs1.
REQ-008 Port: id_use_rs2  in  1  ID instruction reads rs2.
REQ-009 Port: ex_rd  in  5  EX-stage destination index.
REQ-010 Port: ex_is_load  in  1  EX instruction is a load.
REQ-011 Port: mem_branch_taken  in  1  branch or jump resolved taken in MEM.
REQ-012 Port: mem_req  in  1  MEM stage has a memory access in progress.
REQ-013 Port: mem_done  in  1  memory access completes this cycle.
REQ-014 Port: stage_en  out  5  load enables: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
REQ-015 Port: flush  out  3  bubble inserts: bit0 if_id, bit1 id_ex, bit2 ex_mem; a set bit loads a bubble at the edge regardless of stage_en.
REQ-016 Port: ctrl_state  out  2  current FSM state.
REQ-017 Port: stall_cnt  out  CNT_W  count of stall cycles.
REQ-018 Port: flush_cnt  out  CNT_W  count of taken-branch flushes.

Function
REQ-019 The FSM SHALL have the states IDLE=0, RUN=1 and MEM_WAIT=2; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-020 stage_en and flush SHALL be combinational (Mealy) from the state and the inputs, with zero cycles of latency.
REQ-021 When rdy_in=0, the outputs SHALL be stage_en=0 and flush=0, and the state and both counters SHALL hold; this rule overrides all others.
REQ-022 IDLE: stage_en=00000, flush=111; the next state SHALL be RUN.
REQ-023 Load-use hazard (hz) SHALL be: ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-024 RUN, priority (a): mem_req & !mem_done SHALL give stage_en=00000, flush=000, next state MEM_WAIT, stall_cnt+1.
REQ-025 RUN, priority (b): mem_branch_taken SHALL give stage_en=11111, flush=111, flush_cnt+1, and hz SHALL be ignored.
REQ-026 RUN, priority (c): hz SHALL give stage_en=11100, flush=010, stall_cnt+1.
REQ-027 RUN, priority (d): otherwise stage_en=11111, flush=000.
REQ-028 MEM_WAIT with mem_done=0: stage_en=00000, flush=000, stall_cnt+1, remain in MEM_WAIT.
REQ-029 MEM_WAIT with mem_done=1: apply RUN rules (b) to (d), next state RUN.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 mem_branch_taken together with mem_req & !mem_done SHALL resolve to rule (a); the branch is serviced on the mem_done cycle.

Reset
REQ-032 Asserting rst_in SHALL immediately force state=IDLE, stall_cnt=0 and flush_cnt=0, including mid-MEM_WAIT.
REQ-033 During reset, outputs SHALL be stage_en=0, with flush=111 if rdy_in=1 and flush=000 if rdy_in=0.
REQ-034 After reset deassertion, the first rdy_in=1 edge SHALL move the FSM from IDLE to RUN.

Structure
REQ-035 Package pipeline_ctrl_pkg SHALL hold the state encodings, the stage_en and flush bit-index constants, and the CNT_W default.
REQ-036 Sub-module hazard_detect (combinational) SHALL compute hz; the FSM and counters SHALL reside in pipeline_ctrl.

Verification
REQ-037 Reset then rdy_in=1 -> one cycle stage_en=00000, flush=111, then RUN with stage_en=11111.
REQ-038 Load-use: ex_is_load=1, ex_rd=5, id_use_rs2=1, id_rs2=5 -> stage_en=11100, flush=010, stall_cnt 0->1; the same stimulus with ex_rd=0 -> stage_en=11111.
REQ-039 Memory wait: mem_req=1, mem_done=0 for 3 cycles, then mem_done=1 -> 3 cycles of stage_en=0, then stage_en=11111, state RUN, stall_cnt=3.
REQ-040 Taken branch with hz=1 simultaneously -> flush=111, stage_en=11111, flush_cnt=1, stall_cnt unchanged.
REQ-041 rdy_in=0 for 2 cycles in MEM_WAIT -> outputs 0, state and counters frozen; rst_in pulse mid-MEM_WAIT -> IDLE, counters 0.
REQ-042 Counter saturation: force stall_cnt to all-ones, then apply a stall -> stall_cnt stays all-ones.
